// File: rtl/cp0_unit_if.sv
// Bus between the OpenMIPS pipeline and coprocessor 0.
// Groups the MTC0 write port, MFC0 read port, commit events, external
// interrupt levels and the live register outputs.
//
// Handshake: every event (we_i, exc_valid_i, eret_i) is a single-cycle
// valid pulse with no ready. CP0 always accepts it on the rising edge
// where it is high, so there is no back-pressure and nothing is held.
// When events coincide, the order is exception, then ERET, then MTC0.
interface cp0_unit_if #(
  parameter int DATA_W  = 32,
  parameter int INT_NUM = 6
);
  logic              we_i;
  logic [4:0]        waddr_i;
  logic [4:0]        raddr_i;
  logic [DATA_W-1:0] data_i;
  logic [INT_NUM-1:0] int_i;
  logic              exc_valid_i;
  logic [4:0]        exc_code_i;
  logic              eret_i;
  logic [DATA_W-1:0] exc_pc_i;
  logic              in_delayslot_i;
  logic [DATA_W-1:0] bad_addr_i;
  logic [DATA_W-1:0] data_o;
  logic [DATA_W-1:0] count_o;
  logic [DATA_W-1:0] compare_o;
  logic [DATA_W-1:0] status_o;
  logic [DATA_W-1:0] cause_o;
  logic [DATA_W-1:0] epc_o;
  logic              timer_int_o;
  logic              int_req_o;

  // Pipeline side: drives requests, observes CP0 state.
  modport master (
    output we_i, waddr_i, raddr_i, data_i, int_i, exc_valid_i, exc_code_i,
           eret_i, exc_pc_i, in_delayslot_i, bad_addr_i,
    input  data_o, count_o, compare_o, status_o, cause_o, epc_o,
           timer_int_o, int_req_o
  );

  // CP0 side.
  modport slave (
    input  we_i, waddr_i, raddr_i, data_i, int_i, exc_valid_i, exc_code_i,
           eret_i, exc_pc_i, in_delayslot_i, bad_addr_i,
    output data_o, count_o, compare_o, status_o, cause_o, epc_o,
           timer_int_o, int_req_o
  );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0 for the OpenMIPS core: Count (prescaled), Compare, Status,
// Cause, EPC, PRId and Config, with an exception/ERET commit port and a
// masked interrupt request. Define CP0_BADVADDR_EN to add BadVAddr (reg 8).
// There is no FSM here; every register is observable on the bus outputs.
module cp0_unit #(
  parameter int                DATA_W    = 32,
  parameter int                INT_NUM   = 6,
  parameter int                COUNT_DIV = 1,
  parameter logic [DATA_W-1:0] PRID_VAL  = 'h004C0102
) (
  input logic       clk,
  input logic       rst,
  cp0_unit_if.slave bus
);
  localparam int PS_W = 5;
  localparam logic [DATA_W-1:0] STATUS_RST = {4'b0001, {(DATA_W-4){1'b0}}};
  localparam logic [DATA_W-1:0] CONFIG_VAL = DATA_W'(32'h0000_8000);

  logic [PS_W-1:0]   presc;
  logic [DATA_W-1:0] count;
  logic [DATA_W-1:0] compare;
  logic [DATA_W-1:0] status;
  logic [DATA_W-1:0] cause;
  logic [DATA_W-1:0] epc;
  logic              timer_int;

  logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic exc, eret, exl, presc_wrap;
  logic [5:0] ip_ext;

  assign wr_count   = bus.we_i && (bus.waddr_i == 5'd9);
  assign wr_compare = bus.we_i && (bus.waddr_i == 5'd11);
  assign wr_status  = bus.we_i && (bus.waddr_i == 5'd12);
  assign wr_cause   = bus.we_i && (bus.waddr_i == 5'd13);
  assign wr_epc     = bus.we_i && (bus.waddr_i == 5'd14);
  assign exc        = bus.exc_valid_i;
  assign eret       = bus.eret_i;
  assign exl        = status[1];
  assign presc_wrap = (presc == PS_W'(COUNT_DIV - 1));
  assign ip_ext     = 6'(bus.int_i);

  // Prescaler and Count; an MTC0 Count restarts the prescale period.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      presc <= '0;
    end else if (wr_count) begin
      count <= bus.data_i;
      presc <= '0;
    end else if (presc_wrap) begin
      count <= count + DATA_W'(1);
      presc <= '0;
    end else begin
      presc <= presc + PS_W'(1);
    end
  end

  // Compare and the sticky timer interrupt; writing Compare clears it first.
  always_ff @(posedge clk) begin
    if (rst) begin
      compare   <= '0;
      timer_int <= 1'b0;
    end else if (wr_compare) begin
      compare   <= bus.data_i;
      timer_int <= 1'b0;
    end else if ((compare != '0) && (count == compare)) begin
      timer_int <= 1'b1;
    end
  end

  // Status: top nibble is fixed; EXL follows exception > ERET > MTC0.
  always_ff @(posedge clk) begin
    if (rst) begin
      status <= STATUS_RST;
    end else begin
      if (wr_status) status <= {4'b0001, bus.data_i[DATA_W-5:0]};
      if (exc) status[1] <= 1'b1;
      else if (eret) status[1] <= 1'b0;
    end
  end

  // Cause: IP sampled every cycle, soft bits from MTC0, BD/ExcCode on exception.
  always_ff @(posedge clk) begin
    if (rst) begin
      cause <= '0;
    end else begin
      cause[15:10] <= {ip_ext[5] | timer_int, ip_ext[4:0]};
      if (wr_cause) begin
        cause[9:8]   <= bus.data_i[9:8];
        cause[23:22] <= bus.data_i[23:22];
      end
      if (exc) begin
        cause[6:2] <= bus.exc_code_i;
        if (!exl) cause[DATA_W-1] <= bus.in_delayslot_i;
      end
    end
  end

  // EPC: a first-level exception owns it, otherwise MTC0 may write it.
  always_ff @(posedge clk) begin
    if (rst) begin
      epc <= '0;
    end else if (exc && !exl) begin
      epc <= bus.in_delayslot_i ? (bus.exc_pc_i - DATA_W'(4)) : bus.exc_pc_i;
    end else if (wr_epc) begin
      epc <= bus.data_i;
    end
  end

`ifdef CP0_BADVADDR_EN
  logic [DATA_W-1:0] badvaddr;

  // BadVAddr captures the address of AdEL/AdES faults, even when EXL is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr <= '0;
    end else if (exc && ((bus.exc_code_i == 5'd4) || (bus.exc_code_i == 5'd5))) begin
      badvaddr <= bus.bad_addr_i;
    end
  end
`else
  logic [DATA_W-1:0] badvaddr;
  logic              unused_bad_addr;

  assign badvaddr        = '0;
  assign unused_bad_addr = ^bus.bad_addr_i;
`endif

  // MFC0 read mux; no bypass from a same-cycle MTC0.
  always_comb begin
    bus.data_o = '0;
    if (!rst) begin
      case (bus.raddr_i)
        5'd8:    bus.data_o = badvaddr;
        5'd9:    bus.data_o = count;
        5'd11:   bus.data_o = compare;
        5'd12:   bus.data_o = status;
        5'd13:   bus.data_o = cause;
        5'd14:   bus.data_o = epc;
        5'd15:   bus.data_o = PRID_VAL;
        5'd16:   bus.data_o = CONFIG_VAL;
        default: bus.data_o = '0;
      endcase
    end
  end

  assign bus.int_req_o   = (|(cause[15:8] & status[15:8])) & status[0] & ~status[1];
  assign bus.count_o     = count;
  assign bus.compare_o   = compare;
  assign bus.status_o    = status;
  assign bus.cause_o     = cause;
  assign bus.epc_o       = epc;
  assign bus.timer_int_o = timer_int;
endmodule

// File: tb/tb_cp0_unit.sv
// Testbench for cp0_unit: reset checks, a table of MTC0/MFC0 vectors,
// directed timer/exception/interrupt/prescale sequences and a randomized
// run against a reference model of the CP0 register rules.
module tb_cp0_unit;
  logic clk;
  logic rst;

  cp0_unit_if #(.DATA_W(32), .INT_NUM(6)) bus ();
  cp0_unit_if #(.DATA_W(32), .INT_NUM(6)) bus4 ();

  cp0_unit #(.DATA_W(32), .INT_NUM(6), .COUNT_DIV(1)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  cp0_unit #(.DATA_W(32), .INT_NUM(6), .COUNT_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.we_i = 0; bus.waddr_i = 0; bus.raddr_i = 0; bus.data_i = 0;
    bus.int_i = 0; bus.exc_valid_i = 0; bus.exc_code_i = 0; bus.eret_i = 0;
    bus.exc_pc_i = 0; bus.in_delayslot_i = 0; bus.bad_addr_i = 0;
    bus4.we_i = 0; bus4.waddr_i = 0; bus4.raddr_i = 0; bus4.data_i = 0;
    bus4.int_i = 0; bus4.exc_valid_i = 0; bus4.exc_code_i = 0; bus4.eret_i = 0;
    bus4.exc_pc_i = 0; bus4.in_delayslot_i = 0; bus4.bad_addr_i = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    bus.we_i = 1'b1; bus.waddr_i = addr; bus.data_i = data;
    tick();
    bus.we_i = 1'b0;
  endtask

  task automatic raise_exc(input logic [4:0] code, input logic [31:0] pc,
                           input logic ds, input logic [31:0] bad);
    bus.exc_valid_i = 1'b1; bus.exc_code_i = code; bus.exc_pc_i = pc;
    bus.in_delayslot_i = ds; bus.bad_addr_i = bad;
    tick();
    bus.exc_valid_i = 1'b0; bus.in_delayslot_i = 1'b0;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_count, m_compare, m_status, m_cause, m_epc, m_badv;
  logic        m_timer;

  function automatic void model_reset();
    m_count = 0; m_compare = 0; m_status = 32'h1000_0000;
    m_cause = 0; m_epc = 0; m_badv = 0; m_timer = 0;
  endfunction

  // Next state: time passes, then events are applied lowest priority first
  // (MTC0, ERET, exception) so that a higher-priority event overwrites only
  // the fields it owns.
  function automatic void model_step(
    input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic [5:0] irq, input logic ev, input logic [4:0] code,
    input logic er, input logic [31:0] pc, input logic ds, input logic [31:0] ba);
    logic [31:0] n_count, n_compare, n_status, n_cause, n_epc, n_badv;
    logic        n_timer;
    logic        exl_before;
    exl_before = m_status[1];
    n_count    = m_count + 32'd1;
    n_compare  = m_compare;
    n_timer    = m_timer || ((m_compare != 0) && (m_count == m_compare));
    n_status   = m_status;
    n_cause    = m_cause;
    n_epc      = m_epc;
    n_badv     = m_badv;
    n_cause[15:10] = irq;
    n_cause[15]    = irq[5] | m_timer;
    if (we) begin
      case (wa)
        5'd9:  n_count = wd;
        5'd11: begin n_compare = wd; n_timer = 1'b0; end
        5'd12: n_status = {4'b0001, wd[27:0]};
        5'd13: begin n_cause[9:8] = wd[9:8]; n_cause[23:22] = wd[23:22]; end
        5'd14: n_epc = wd;
        default: ;
      endcase
    end
    if (er) n_status[1] = 1'b0;
    if (ev) begin
      n_status[1]  = 1'b1;
      n_cause[6:2] = code;
      if (!exl_before) begin
        n_cause[31] = ds;
        n_epc       = ds ? pc - 32'd4 : pc;
      end
`ifdef CP0_BADVADDR_EN
      if (code == 5'd4 || code == 5'd5) n_badv = ba;
`else
      n_badv = ba & 32'd0;
`endif
    end
    m_count = n_count; m_compare = n_compare; m_status = n_status;
    m_cause = n_cause; m_epc = n_epc; m_badv = n_badv; m_timer = n_timer;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h004C_0102;
      5'd16:   return 32'h0000_8000;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_int_req();
    return (|(m_cause[15:8] & m_status[15:8])) & m_status[0] & ~m_status[1];
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  logic [31:0] expected_bad;
  logic [4:0]  raddr_pool[10];

  // randomized stimulus fields
  logic        r_we, r_ev, r_er, r_ds, rst_now;
  logic [4:0]  r_wa, r_code, r_ra;
  logic [31:0] r_wd, r_pc, r_ba;
  logic [5:0]  r_irq;
  int          wait_cnt;

  initial begin
    vecs[0] = '{"tbl_status_all", 5'd12, 32'hFFFF_FFFF, 5'd12, 32'h1FFF_FFFF};
    vecs[1] = '{"tbl_epc",        5'd14, 32'h1234_5678, 5'd14, 32'h1234_5678};
    vecs[2] = '{"tbl_cause_mask", 5'd13, 32'hFFFF_FFFF, 5'd13, 32'h00C0_0300};
    vecs[3] = '{"tbl_compare",    5'd11, 32'hDEAD_BEEF, 5'd11, 32'hDEAD_BEEF};
    vecs[4] = '{"tbl_prid_ro",    5'd15, 32'h0000_0000, 5'd15, 32'h004C_0102};
    vecs[5] = '{"tbl_config_ro",  5'd16, 32'h0000_0000, 5'd16, 32'h0000_8000};
    vecs[6] = '{"tbl_badv_ro",    5'd8,  32'h5555_5555, 5'd8,  32'h0000_0000};
    vecs[7] = '{"tbl_unmapped",   5'd3,  32'hFFFF_FFFF, 5'd3,  32'h0000_0000};
    vecs[8] = '{"tbl_status_zero",5'd12, 32'h0000_0000, 5'd12, 32'h1000_0000};
    vecs[9] = '{"tbl_count_load", 5'd9,  32'h0000_0100, 5'd9,  32'h0000_0100};
    raddr_pool = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd0, 5'd20};

    // ---- reset state ----
    drive_idle();
    rst = 1'b1;
    tick();
    tick();
    bus.raddr_i = 5'd15;
    #1;
    check("rst_data_forced", bus.data_o, 32'h0);
    check("rst_count", bus.count_o, 32'h0);
    check("rst_compare", bus.compare_o, 32'h0);
    check("rst_status", bus.status_o, 32'h1000_0000);
    check("rst_cause", bus.cause_o, 32'h0);
    check("rst_epc", bus.epc_o, 32'h0);
    check("rst_timer", {31'h0, bus.timer_int_o}, 32'h0);
    check("rst_int_req", {31'h0, bus.int_req_o}, 32'h0);
    rst = 1'b0;
    #1;
    check("prid_after_rst", bus.data_o, 32'h004C_0102);

    // ---- table-driven MTC0/MFC0 vectors ----
    for (int i = 0; i < 10; i++) begin
      bus.raddr_i = vecs[i].raddr;
      mtc0(vecs[i].waddr, vecs[i].wdata);
      check(vecs[i].name, bus.data_o, vecs[i].exp);
    end

    // ---- timer ----
    do_reset();
    mtc0(5'd11, 32'd10);
    wait_cnt = 0;
    while (bus.count_o != 32'd10 && wait_cnt < 30) begin
      tick();
      wait_cnt++;
    end
    check("timer_reach_count10", bus.count_o, 32'd10);
    check("timer_not_yet", {31'h0, bus.timer_int_o}, 32'h0);
    tick();
    check("timer_set", {31'h0, bus.timer_int_o}, 32'h1);
    tick();
    check("timer_cause15", {31'h0, bus.cause_o[15]}, 32'h1);
    check("timer_sticky", {31'h0, bus.timer_int_o}, 32'h1);
    mtc0(5'd11, 32'd50);
    check("timer_cleared", {31'h0, bus.timer_int_o}, 32'h0);
    check("timer_new_compare", bus.compare_o, 32'd50);

    // ---- delay-slot exception, nested exception, ERET vs MTC0 ----
    do_reset();
    raise_exc(5'd8, 32'h100, 1'b1, 32'h0);
    check("ds_epc", bus.epc_o, 32'hFC);
    check("ds_bd", {31'h0, bus.cause_o[31]}, 32'h1);
    check("ds_code", {27'h0, bus.cause_o[6:2]}, 32'd8);
    check("ds_exl", {31'h0, bus.status_o[1]}, 32'h1);
    raise_exc(5'd3, 32'h200, 1'b0, 32'h0);
    check("nested_epc_kept", bus.epc_o, 32'hFC);
    check("nested_bd_kept", {31'h0, bus.cause_o[31]}, 32'h1);
    check("nested_code", {27'h0, bus.cause_o[6:2]}, 32'd3);
    bus.eret_i = 1'b1;
    mtc0(5'd12, 32'h0000_FF03);
    bus.eret_i = 1'b0;
    check("eret_over_mtc0", bus.status_o, 32'h1000_FF01);
    // exception beats a same-cycle MTC0 Status on EXL only
    bus.exc_valid_i = 1'b1; bus.exc_code_i = 5'd1; bus.exc_pc_i = 32'h300;
    mtc0(5'd12, 32'h0000_0401);
    bus.exc_valid_i = 1'b0;
    check("exc_over_mtc0", bus.status_o, 32'h1000_0403);
    check("exc_first_level_epc", bus.epc_o, 32'h300);

    // ---- interrupt masking ----
    do_reset();
    bus.int_i = 6'b000100;
    mtc0(5'd12, 32'h1000_1001);
    check("irq_req_on", {31'h0, bus.int_req_o}, 32'h1);
    raise_exc(5'd0, 32'h400, 1'b0, 32'h0);
    check("irq_masked_exl", {31'h0, bus.int_req_o}, 32'h0);
    bus.eret_i = 1'b1;
    tick();
    bus.eret_i = 1'b0;
    check("irq_after_eret", {31'h0, bus.int_req_o}, 32'h1);
    bus.int_i = 6'b0;

    // ---- BadVAddr ----
`ifdef CP0_BADVADDR_EN
    expected_bad = 32'h8000_0003;
`else
    expected_bad = 32'h0;
`endif
    raise_exc(5'd4, 32'h500, 1'b0, 32'h8000_0003);
    bus.raddr_i = 5'd8;
    #1;
    check("badv_adel", bus.data_o, expected_bad);
    raise_exc(5'd6, 32'h600, 1'b0, 32'h0000_1111);
    check("badv_other_code", bus.data_o, expected_bad);

    // ---- prescale (COUNT_DIV=4 instance) ----
    do_reset();
    repeat (40) tick();
    check("presc_count40", bus4.count_o, 32'd10);
    bus4.we_i = 1'b1; bus4.waddr_i = 5'd9; bus4.data_i = 32'hFFFF_FFFF;
    tick();
    bus4.we_i = 1'b0;
    check("presc_load", bus4.count_o, 32'hFFFF_FFFF);
    repeat (3) tick();
    check("presc_hold", bus4.count_o, 32'hFFFF_FFFF);
    tick();
    check("presc_wrap", bus4.count_o, 32'h0);

    // ---- randomized run against the model ----
    do_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      rst_now = (i == 200);
      r_we   = ($urandom_range(0, 2) == 0);
      r_wa   = raddr_pool[$urandom_range(0, 9)];
      if ($urandom_range(0, 3) == 0) r_wa = 5'd11;
      r_wd   = $urandom();
      if (r_wa == 5'd11 && $urandom_range(0, 1) == 0) r_wd = m_count + $urandom_range(1, 12);
      r_irq  = 6'($urandom_range(0, 63));
      r_ev   = ($urandom_range(0, 7) == 0);
      r_code = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0) r_code = 5'($urandom_range(4, 5));
      r_er   = ($urandom_range(0, 7) == 0);
      r_pc   = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      r_ds   = $urandom_range(0, 1) == 1;
      r_ba   = $urandom();
      r_ra   = raddr_pool[$urandom_range(0, 9)];
      bus.we_i = r_we; bus.waddr_i = r_wa; bus.data_i = r_wd; bus.int_i = r_irq;
      bus.exc_valid_i = r_ev; bus.exc_code_i = r_code; bus.eret_i = r_er;
      bus.exc_pc_i = r_pc; bus.in_delayslot_i = r_ds; bus.bad_addr_i = r_ba;
      bus.raddr_i = r_ra;
      rst = rst_now;
      if (rst_now) model_reset();
      else model_step(r_we, r_wa, r_wd, r_irq, r_ev, r_code, r_er, r_pc, r_ds, r_ba);
      tick();
      check("rnd_count", bus.count_o, m_count);
      check("rnd_compare", bus.compare_o, m_compare);
      check("rnd_status", bus.status_o, m_status);
      check("rnd_cause", bus.cause_o, m_cause);
      check("rnd_epc", bus.epc_o, m_epc);
      check("rnd_timer", {31'h0, bus.timer_int_o}, {31'h0, m_timer});
      check("rnd_int_req", {31'h0, bus.int_req_o}, {31'h0, model_int_req()});
      check("rnd_data", bus.data_o, rst_now ? 32'h0 : model_read(r_ra));
      rst = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
